// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [31:0] TEXT_BASE  = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE  = 32'h1001_0000;
    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned IMEM_WORDS = 2048;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Shifts bytes in little-endian order and presents each completed 32-bit word
// with a one-cycle valid pulse in the cycle after its 4th byte.
module byte_packer (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        word_last,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [31:0] sreg;
    logic [1:0]  cnt;

    assign word_last = (cnt == 2'd3);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sreg       <= '0;
            cnt        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else if (clr) begin
            sreg       <= '0;
            cnt        <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (shift_en) begin
                // newest byte enters at the top, so the first byte ends up in [7:0]
                sreg <= {byte_in, sreg[31:8]};
                cnt  <= cnt + 2'd1;
                if (word_last) begin
                    word       <= {byte_in, sreg[31:8]};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory
// and holds the cpu in reset until a load completes successfully.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t         state, state_nx;
    logic           accept;
    logic           load_start;
    logic           hdr_bad;
    logic           last_word;
    logic           timed_out;
    logic [7:0]     len_lo;
    logic [15:0]    hdr_n;
    logic [15:0]    n_words;
    logic [ADDR_W:0] wr_idx;
    logic [7:0]     csum;
    logic [31:0]    idle_cnt;
    logic           word_last;

    assign accept     = rx_valid & rx_ready;
    assign load_start = start & ((state == IDLE) | (state == DONE) | (state == ERR));
    assign hdr_n      = {rx_data, len_lo};
    assign hdr_bad    = (hdr_n == 16'd0) || (32'(hdr_n) > (32'd1 << ADDR_W));
    assign last_word  = ((32'(wr_idx) + 32'd1) == 32'(n_words));
    // fires on the cycle whose count would reach the limit, so ERR lands exactly
    // TIMEOUT_CYC cycles after the last accepted byte
    assign timed_out  = !accept && (idle_cnt == TIMEOUT_CYC - 32'd1);

    always_comb begin
        state_nx = state;
        rx_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cpu_rst  = 1'b1;
        case (state)
            IDLE, DONE, ERR: if (start) state_nx = LEN0;
            LEN0:            if (accept) state_nx = LEN1;
            LEN1:            if (accept) state_nx = hdr_bad ? ERR : DATA;
            DATA:            if (accept && word_last && last_word) state_nx = CSUM;
            CSUM:            if (accept) state_nx = (rx_data == csum) ? DONE : ERR;
            default:         state_nx = IDLE;
        endcase
        case (state)
            LEN0, LEN1, DATA, CSUM: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (timed_out) state_nx = ERR;
            end
            DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
            end
            ERR:     err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            len_lo    <= '0;
            n_words   <= '0;
            wr_idx    <= '0;
            csum      <= '0;
            idle_cnt  <= '0;
            imem_addr <= '0;
        end else begin
            state <= state_nx;
            if (load_start) begin
                wr_idx   <= '0;
                csum     <= '0;
                idle_cnt <= '0;
            end else if (busy) begin
                idle_cnt <= accept ? 32'd0 : idle_cnt + 32'd1;
            end
            if (state == LEN0 && accept) len_lo <= rx_data;
            if (state == LEN1 && accept) n_words <= hdr_n;
            if (state == DATA && accept) begin
                csum <= csum + rx_data;
                if (word_last) begin
                    imem_addr <= wr_idx[ADDR_W-1:0];
                    wr_idx    <= wr_idx + 1'b1;
                end
            end
        end
    end

    byte_packer u_packer (
        .clk_in     (clk_in),
        .reset      (reset),
        .clr        (load_start),
        .shift_en   ((state == DATA) && accept),
        .byte_in    (rx_data),
        .word_last  (word_last),
        .word       (imem_wdata),
        .word_valid (imem_we)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader with a byte-level reference model.
module tb_imem_loader;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [10:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader #(.ADDR_W(11), .TIMEOUT_CYC(16)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_t;

    int           errors = 0;
    int           checks = 0;
    wr_t          exp_q[$];
    byte unsigned stim[$];
    bit           exp_done;
    int           exp_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // scoreboard monitor: every write strobe must match the oldest expected write
    always @(negedge clk_in) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %h, expected none", imem_addr, imem_wdata);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), w.addr);
                check("wr_data", imem_wdata, w.data);
            end
        end
    end

    // Reference model: derives writes and outcome straight from the byte stream.
    task automatic model_expect();
        int unsigned n;
        int unsigned sum;
        n = stim[0] + 256 * stim[1];
        if (n == 0 || n > 2048) begin
            exp_done = 1'b0;
            exp_len  = 2;
        end else begin
            sum = 0;
            for (int unsigned i = 0; i < n; i++) begin
                wr_t w;
                int unsigned b;
                b      = 2 + 4 * i;
                w.addr = i;
                w.data = stim[b] + (stim[b+1] << 8) + (stim[b+2] << 16) + (stim[b+3] << 24);
                sum    = sum + stim[b] + stim[b+1] + stim[b+2] + stim[b+3];
                exp_q.push_back(w);
            end
            exp_done = (stim[2 + 4 * n] == (sum % 256));
            exp_len  = 4 * n + 3;
        end
    endtask

    task automatic build_load(input int unsigned n, input bit good);
        int unsigned sum;
        stim.delete();
        stim.push_back(8'(n));
        stim.push_back(8'(n >> 8));
        if (n != 0 && n <= 2048) begin
            sum = 0;
            for (int unsigned i = 0; i < 4 * n; i++) begin
                byte unsigned b;
                b   = 8'($urandom);
                sum = sum + b;
                stim.push_back(b);
            end
            stim.push_back(good ? 8'(sum) : (8'(sum) ^ 8'h5A));
        end
    endtask

    task automatic do_start(input bit rv_with_start);
        start    = 1'b1;
        rx_valid = rv_with_start;
        rx_data  = stim[0];
        @(posedge clk_in); #1;
        start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_cpu_rst", cpu_rst, 1'b1);
    endtask

    task automatic send_byte(input byte unsigned b, input int unsigned gap);
        bit rdy;
        bit acc;
        repeat (gap) begin
            rx_valid = 1'b0;
            @(posedge clk_in); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        acc      = 1'b0;
        for (int c = 0; c < 100; c++) begin
            rdy = rx_ready;
            @(posedge clk_in); #1;
            if (rdy) begin
                acc = 1'b1;
                break;
            end
        end
        rx_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL byte_accept: got no accept in 100 cycles, expected accept");
        end
    endtask

    task automatic run_load(input string tag, input int unsigned maxgap, input bit rv_start);
        model_expect();
        do_start(rv_start);
        for (int i = 0; i < exp_len; i++) send_byte(stim[i], $urandom_range(maxgap, 0));
        check({tag, "_done"}, done, exp_done);
        check({tag, "_err"}, err, !exp_done);
        check({tag, "_cpu_rst"}, cpu_rst, !exp_done);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, rx_ready, 1'b0);
        check({tag, "_we"}, imem_we, 1'b0);
        check({tag, "_addr"}, 32'(imem_addr), 0);
        check({tag, "_wdata"}, imem_wdata, 32'h0);
        check({tag, "_cpu_rst"}, cpu_rst, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish by 5 ms, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #23;
        check_reset_outputs("rst");
        @(posedge clk_in); #1;
        reset = 1'b1;
        repeat (4) @(posedge clk_in);
        #1;
        check("idle_hold_busy", busy, 1'b0);
        check("idle_hold_cpu_rst", cpu_rst, 1'b1);

        // nominal two-word image
        stim = '{8'h02, 8'h00, 8'h3C, 8'h08, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h57};
        run_load("nominal", 0, 1'b0);
        stim = '{8'h02, 8'h00, 8'h3C, 8'h08, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h57};
        run_load("backpressure", 3, 1'b1);

        stim = '{8'h00, 8'h00};
        run_load("hdr_zero", 0, 1'b0);
        stim = '{8'h01, 8'h08};
        run_load("hdr_big", 1, 1'b0);

        stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        run_load("csum_bad", 0, 1'b0);

        // stall after the third accepted byte
        stim = '{8'h01, 8'h00, 8'hAA};
        do_start(1'b0);
        for (int i = 0; i < 3; i++) send_byte(stim[i], 0);
        k = 0;
        while (err !== 1'b1 && k < 40) begin
            @(posedge clk_in); #1;
            k++;
        end
        check("timeout_cycles", k, 16);
        check("timeout_cpu_rst", cpu_rst, 1'b1);

        for (int t = 0; t < 6; t++) begin
            build_load($urandom_range(6, 1), 1'($urandom_range(1, 0)));
            run_load("random", 3, 1'($urandom_range(1, 0)));
        end

        // reset asserted in the middle of the data phase
        build_load(2, 1'b1);
        model_expect();
        do_start(1'b0);
        for (int i = 0; i < 7; i++) send_byte(stim[i], 0);
        rx_valid = 1'b1;
        rx_data  = stim[7];
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        repeat (3) @(posedge clk_in);
        #1;
        reset    = 1'b1;
        rx_valid = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        check("midrst_idle_busy", busy, 1'b0);
        check("midrst_idle_cpu_rst", cpu_rst, 1'b1);

        // reload from DONE with a full-size image
        stim = '{8'h02, 8'h00, 8'h3C, 8'h08, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h57};
        run_load("preload", 0, 1'b0);
        build_load(2048, 1'b1);
        run_load("reload", 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning the instruction-memory word-index width (2048 words).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000, meaning the maximum number of idle cycles allowed between accepted bytes.
REQ-003 SHALL have port clk_in  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port rx_valid  input  1  byte-stream valid.
REQ-007 SHALL have port rx_data  input  8  byte-stream data.
REQ-008 SHALL have port rx_ready  output  1  byte-stream ready.
REQ-009 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port imem_addr  output  ADDR_W  word index; index 0 is PC 0x0040_0000.
REQ-011 SHALL have port imem_wdata  output  32  instruction word.
REQ-012 SHALL have port cpu_rst  output  1  active-high hold-in-reset for the cpu.
REQ-013 SHALL have port busy  output  1  a load is in progress.
REQ-014 SHALL have port done  output  1  the last load succeeded.
REQ-015 SHALL have port err  output  1  the last load failed.

Function
REQ-016 SHALL accept a byte only in a cycle where rx_valid and rx_ready are both 1.
REQ-017 SHALL assert rx_ready in states LEN0, LEN1, DATA and CSUM, and only in those states.
REQ-018 SHALL implement FSM states IDLE, LEN0, LEN1, DATA, CSUM, DONE and ERR.
REQ-019 SHALL take the transition IDLE/DONE/ERR -> LEN0 on start; start SHALL be ignored in all other states.
REQ-020 SHALL take LEN0 -> LEN1 on an accepted byte, which is the low byte of the word count N.
REQ-021 SHALL take LEN1 -> DATA on an accepted byte, which is the high byte of N; if N = 0 or N > 2**ADDR_W, it SHALL go to ERR instead.
REQ-022 SHALL, in DATA, assemble each group of 4 accepted bytes into one word, little-endian (first byte is [7:0]).
REQ-023 SHALL write each completed word exactly once: imem_we = 1 for one cycle, in the cycle after the 4th byte is accepted, with imem_addr = the word index (0..N-1) and imem_wdata = the word.
REQ-024 SHALL take DATA -> CSUM after the 4*N-th byte is accepted.
REQ-025 SHALL, in CSUM, compare the accepted byte with the modulo-256 sum of all data bytes; on a match it SHALL go to DONE, otherwise to ERR.
REQ-026 SHALL, in states LEN0..CSUM, count the cycles since the last accepted byte (or since entry into LEN0); when the count reaches TIMEOUT_CYC it SHALL go to ERR, and any accepted byte SHALL clear the count.
REQ-027 SHALL hold imem_we = 0 outside the write cycle defined in REQ-023.
REQ-028 SHALL assert cpu_rst in every state except DONE, and SHALL deassert it in the cycle DONE is entered.
REQ-029 SHALL drive busy = 1 in LEN0..CSUM, done = 1 only in DONE, and err = 1 only in ERR.
REQ-030 SHALL accept no byte when start and rx_valid arrive together in IDLE; the next cycle is LEN0.
REQ-031 SHALL treat a start in DONE as a reload: it SHALL reassert cpu_rst immediately, clear the checksum, and clear the word index.
REQ-032 SHALL not perform writes after a checksum error; words already written SHALL remain in the memory.

Reset
REQ-033 SHALL, while reset = 0, asynchronously force: state IDLE; rx_ready 0; imem_we 0; imem_addr 0; imem_wdata 0; cpu_rst 1; busy 0; done 0; err 0; all counters and the checksum 0.
REQ-034 SHALL abort a load in progress when reset is asserted mid-operation, with no further write strobe.
REQ-035 SHALL, after reset is released, remain in IDLE until start is asserted.

Structure
REQ-036 SHALL place in the shared package: the FSM state type; the constants TEXT_BASE = 32'h0040_0000, DATA_BASE = 32'h1001_0000 and HDR_BYTES = 2; and the default IMEM word count 2048.
REQ-037 SHALL contain one sub-module, byte_packer, which shifts in bytes and flags word completion after every 4th byte; the FSM, counters and checksum SHALL stay in imem_loader.

Verification
REQ-038 SHALL cover the nominal case: start; bytes 02 00, 3C 08 00 00 ... (8 data bytes) plus the correct checksum -> two writes at addr 0 and 1 (word 0 = 0x0000083C), then done = 1 and cpu_rst = 0.
REQ-039 SHALL cover a bad header: header 00 00 -> err = 1 one cycle after the 2nd byte, no imem_we, cpu_rst = 1.
REQ-040 SHALL cover a checksum mismatch: N = 1, data 11 22 33 44, checksum 00 (expected 0xAA) -> one write of 0x44332211, then err = 1.
REQ-041 SHALL cover back-pressure and timeout: rx_valid toggled randomly gives the same result as REQ-038; with TIMEOUT_CYC = 16 and a stall after byte 3 -> err exactly 16 cycles after the last accepted byte.
REQ-042 SHALL cover reset mid-load: reset = 0 during the DATA phase -> all outputs immediately at reset values, with no write strobe during or after reset.
REQ-043 SHALL cover a reload: start in DONE -> cpu_rst = 1 in the next cycle, and a second load of N = 2048 writes addresses 0..2047.
